// File: rtl/issue_queue.sv
// issue_queue: age-ordered compacting issue queue with writeback wakeup and oldest-ready-first select.
// Optional build macro IQ_WB_BYPASS_EN lets same-cycle writeback wakeups feed the select path.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 2
`endif
`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif

module issue_queue #(
    parameter int IQ_DEPTH   = 8,
    parameter int PREG_WIDTH = 6
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [`DISPATCH_WIDTH-1:0]                       dispatch_valid_i,
    input  logic [`DISPATCH_WIDTH-1:0][3*PREG_WIDTH+1:0]     dispatch_data_i,
    output logic [`DISPATCH_WIDTH-1:0]                       dispatch_ready_o,
    output logic                                             issue_valid_o,
    output logic [3*PREG_WIDTH+1:0]                          issue_data_o,
    input  logic                                             issue_ready_i,
    input  logic [`WB_WIDTH-1:0]                             wb_valid_i,
    input  logic [`WB_WIDTH-1:0][PREG_WIDTH-1:0]             wb_pdest_i,
    input  logic                                             flush_i
);

    localparam int DW  = `DISPATCH_WIDTH;
    localparam int WBW = `WB_WIDTH;
    localparam int CW  = $clog2(IQ_DEPTH + 1);

    typedef struct packed {
        logic [PREG_WIDTH-1:0] src0;
        logic                  src0_ready;
        logic [PREG_WIDTH-1:0] src1;
        logic                  src1_ready;
        logic [PREG_WIDTH-1:0] pdest;
    } entry_t;

    entry_t          entry_q [IQ_DEPTH];
    entry_t          entry_d [IQ_DEPTH];
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    entry_t          view    [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] cand;
    logic            found;
    int              sel_idx;
    entry_t          sel_entry;
    logic            iss;

    // Sets the ready bit of any source operand whose tag matches a valid writeback lane.
    function automatic entry_t wake(input entry_t e,
                                    input logic [WBW-1:0] v,
                                    input logic [WBW-1:0][PREG_WIDTH-1:0] tag);
        entry_t r;
        r = e;
        for (int j = 0; j < WBW; j++) begin
            if (v[j] && (tag[j] == e.src0)) r.src0_ready = 1'b1;
            if (v[j] && (tag[j] == e.src1)) r.src1_ready = 1'b1;
        end
        return r;
    endfunction

    // Free slots come from the registered count only, so a same-cycle issue never reopens a lane.
    always_comb begin
        for (int i = 0; i < DW; i++) begin
            dispatch_ready_o[i] = !rst && ((IQ_DEPTH - int'(cnt_q)) > i);
        end
    end

    always_comb begin
        for (int k = 0; k < IQ_DEPTH; k++) begin
`ifdef IQ_WB_BYPASS_EN
            view[k] = wake(entry_q[k], wb_valid_i, wb_pdest_i);
`else
            view[k] = entry_q[k];
`endif
            cand[k] = (k < int'(cnt_q)) && view[k].src0_ready && view[k].src1_ready;
        end
    end

    // Scan from the youngest down so the oldest candidate wins.
    always_comb begin
        found     = 1'b0;
        sel_idx   = 0;
        sel_entry = '0;
        for (int k = IQ_DEPTH - 1; k >= 0; k--) begin
            if (cand[k]) begin
                found     = 1'b1;
                sel_idx   = k;
                sel_entry = view[k];
            end
        end
    end

    assign issue_valid_o = found && !flush_i && !rst;
    assign issue_data_o  = sel_entry;
    assign iss           = issue_valid_o && issue_ready_i;

    always_comb begin
        int     base;
        int     acc;
        int     cnt_n;
        entry_t shifted;
        base  = int'(cnt_q) - (iss ? 1 : 0);
        acc   = 0;
        for (int i = 0; i < DW; i++) begin
            if (dispatch_valid_i[i] && dispatch_ready_o[i]) acc = acc + 1;
        end
        cnt_n = base + acc;

        for (int k = 0; k < IQ_DEPTH; k++) begin
            shifted = entry_q[k];
            if (iss && (k >= sel_idx)) begin
                if (k + 1 < IQ_DEPTH) shifted = entry_q[(k + 1) % IQ_DEPTH];
                else                  shifted = '0;
            end
            entry_d[k] = wake(shifted, wb_valid_i, wb_pdest_i);
            for (int i = 0; i < DW; i++) begin
                if (dispatch_valid_i[i] && dispatch_ready_o[i] && (base + i == k)) begin
                    entry_d[k] = wake(entry_t'(dispatch_data_i[i]), wb_valid_i, wb_pdest_i);
                end
            end
            if (k >= cnt_n || flush_i) entry_d[k] = '0;
        end

        cnt_d = flush_i ? '0 : CW'(cnt_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int k = 0; k < IQ_DEPTH; k++) entry_q[k] <= '0;
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < IQ_DEPTH; k++) entry_q[k] <= entry_d[k];
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Randomized bench for issue_queue against a queue-based age-ordered reference model.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 2
`endif
`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif

module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int PW    = 6;
    localparam int EW    = 3*PW + 2;
    localparam int DW    = `DISPATCH_WIDTH;
    localparam int WBW   = `WB_WIDTH;
    localparam int NCYC  = 4000;

    typedef struct {
        bit [PW-1:0] s0;
        bit          r0;
        bit [PW-1:0] s1;
        bit          r1;
        bit [PW-1:0] pd;
    } ent_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [DW-1:0]            dv;
    logic [DW-1:0][EW-1:0]    dd;
    logic [DW-1:0]            dr;
    logic                     iv;
    logic [EW-1:0]            idata;
    logic                     ir;
    logic [WBW-1:0]           wv;
    logic [WBW-1:0][PW-1:0]   wt;
    logic                     flush;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    ent_t q[$];
    ent_t lane[DW];

    issue_queue #(.IQ_DEPTH(DEPTH), .PREG_WIDTH(PW)) dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_valid_i (dv),
        .dispatch_data_i  (dd),
        .dispatch_ready_o (dr),
        .issue_valid_o    (iv),
        .issue_data_o     (idata),
        .issue_ready_i    (ir),
        .wb_valid_i       (wv),
        .wb_pdest_i       (wt),
        .flush_i          (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input ent_t e);
        return {e.s0, e.r0, e.s1, e.r1, e.pd};
    endfunction

    function automatic ent_t woken(input ent_t e);
        ent_t r = e;
        for (int j = 0; j < WBW; j++) begin
            if (wv[j] && wt[j] == e.s0) r.r0 = 1'b1;
            if (wv[j] && wt[j] == e.s1) r.r1 = 1'b1;
        end
        return r;
    endfunction

    initial begin
        int            phase;
        int            n;
        int            sel;
        logic [DW-1:0] exp_rdy;
        logic          exp_iv;
        logic [EW-1:0] exp_data;
        ent_t          v;

        rst = 1'b1; dv = '0; dd = '0; ir = 1'b0; wv = '0; wt = '0; flush = 1'b0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            phase = (cyc / 300) % 4;
            rst   = (cyc < 3) || ($urandom_range(0, 699) == 0);
            flush = ($urandom_range(0, 99) == 0);
            // phase 0 fills the queue with mostly unready entries; phase 3 is wakeup-heavy
            ir    = (phase == 0) ? ($urandom_range(0, 7) == 0) :
                    (phase == 1) ? 1'b1 : $urandom_range(0, 1);
            n     = $urandom_range(0, DW);
            dv    = '0;
            for (int i = 0; i < DW; i++) begin
                lane[i].s0 = PW'($urandom_range(0, 7));
                lane[i].s1 = PW'($urandom_range(0, 7));
                lane[i].pd = PW'($urandom_range(0, 63));
                lane[i].r0 = (phase == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
                lane[i].r1 = ($urandom_range(0, 2) != 0);
                dd[i]      = pack(lane[i]);
                if (i < n) dv[i] = 1'b1;
            end
            for (int j = 0; j < WBW; j++) begin
                wv[j] = (phase == 3) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
                wt[j] = PW'($urandom_range(0, 7));
            end
            #1;

            for (int i = 0; i < DW; i++) exp_rdy[i] = !rst && ((DEPTH - q.size()) > i);
            sel      = -1;
            exp_data = '0;
            for (int k = 0; k < q.size(); k++) begin
`ifdef IQ_WB_BYPASS_EN
                v = woken(q[k]);
`else
                v = q[k];
`endif
                if (sel < 0 && v.r0 && v.r1) begin
                    sel      = k;
                    exp_data = pack(v);
                end
            end
            exp_iv = (sel >= 0) && !flush && !rst;

            check("dispatch_ready", 32'(dr), 32'(exp_rdy));
            check("issue_valid", 32'(iv), 32'(exp_iv));
            check("issue_data", 32'(idata), 32'(exp_data));

            if (rst || flush) begin
                q.delete();
            end else begin
                if (exp_iv && ir) q.delete(sel);
                foreach (q[k]) q[k] = woken(q[k]);
                for (int i = 0; i < DW; i++) begin
                    if (dv[i] && exp_rdy[i]) q.push_back(woken(lane[i]));
                end
            end
            @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Consumer end of the dispatch queue's read handshake: accepts up to `DISPATCH_WIDTH dispatched DqEntrySt entries per cycle over per-lane valid/ready.
- Holds them in an age-ordered compacting buffer and tracks operand readiness from writeback wakeups.
- Issues one operand-ready entry per cycle, oldest first, to the execute stage.

Parameters:
- IQ_DEPTH, 8, number of entries; must be >= `DISPATCH_WIDTH.
- PREG_WIDTH, 6, physical register tag width; matches DqEntrySt src0/src1/pdest.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- dispatch_valid_i  input  `DISPATCH_WIDTH  per-lane entry valid; always a contiguous prefix from lane 0.
- dispatch_data_i  input  `DISPATCH_WIDTH x DqEntrySt  entries; fields src0, src0_ready, src1, src1_ready, pdest.
- dispatch_ready_o  output  `DISPATCH_WIDTH  per-lane accept.
- issue_valid_o  output  1  selected entry ready to issue.
- issue_data_o  output  DqEntrySt  selected entry.
- issue_ready_i  input  1  execute stage accepts.
- wb_valid_i  input  `WB_WIDTH  writeback lane valid.
- wb_pdest_i  input  `WB_WIDTH x PREG_WIDTH  writeback tags.
- flush_i  input  1  discard all entries.

Behaviour:
- State: entry[0..IQ_DEPTH-1], with entry 0 the oldest, plus cnt_q of $clog2(IQ_DEPTH+1) bits. Entries at index >= cnt_q are invalid.
- Reset (rst sampled high at a posedge): cnt_q=0 and all entry fields cleared.
- While rst is high: dispatch_ready_o=0 and issue_valid_o=0.
- After reset: dispatch_ready_o is all ones; issue_valid_o=0.
- Dispatch ready: dispatch_ready_o[i] = (IQ_DEPTH - cnt_q) > i, computed from registered cnt_q only. It does not depend on same-cycle issue or on dispatch_valid_i.
- Dispatch accept: lane i transfers when dispatch_valid_i[i] & dispatch_ready_o[i]. acc = number of accepted lanes.
- Dispatch placement: accepted lane i is written at index cnt_q - iss + i, where iss = 1 if an issue handshake fires this cycle, else 0. Lane order is preserved as age order.
- Select: candidate k satisfies k < cnt_q, src0_ready and src1_ready. The selected entry is the lowest-index candidate.
  - issue_valid_o = a candidate exists and !flush_i.
  - issue_data_o = the selected entry; all zeros when there is no candidate.
- Issue: the handshake is issue_valid_o & issue_ready_i. The issued entry is removed and entries above it shift down by one in the same edge, so age order is preserved.
- No stability guarantee: issue_valid_o and issue_data_o may change between cycles without a handshake, e.g. when an older entry wakes up.
- Wakeup: for each valid wb lane j:
  - any stored entry with src0 == wb_pdest_i[j] sets src0_ready=1 at the next edge; same rule for src1.
  - Entries accepted in the same cycle also snoop wb, so they enter already woken.
  - Multiple wb lanes may hit the same entry; the result is the OR of the hits.
- Next count: cnt_n = cnt_q - iss + acc. It never exceeds IQ_DEPTH, because ready is computed against cnt_q.
- Flush: when flush_i is high, cnt_n=0 and all entries are cleared.
  - Flush has priority over dispatch, issue and wakeup.
  - Lanes shown ready in the flush cycle are dropped.
  - issue_valid_o is forced to 0.
- Boundaries:
  - Full (cnt_q=IQ_DEPTH): dispatch_ready_o=0, and a same-cycle issue does not reopen it until the next cycle.
  - Empty: issue_valid_o=0.
  - Simultaneous dispatch, issue and wakeup in one cycle are all honoured.
  - Reset mid-operation discards all contents.

Optional Feature:
- Macro: IQ_WB_BYPASS_EN.
- Defined: wakeup also applies combinationally to select. A stored entry whose last missing operand matches a wb tag in cycle t may issue in cycle t; its issue_data_o shows the ready bits set. Same-cycle dispatched entries are still not selectable until t+1.
- Undefined: woken entries are selectable no earlier than t+1.

Test Plan:
- Reset, then 2 lanes valid with both operands ready -> dispatch_ready_o all 1, cnt_q=2 next cycle; issue_valid_o=1 with the lane-0 entry; with issue_ready_i=1, lane-1 entry issues the following cycle.
- Fill to IQ_DEPTH=8 with src0_ready=0 -> dispatch_ready_o=0 and issue_valid_o=0; issue one entry -> ready lane 0 returns the cycle after.
- Entries A (src0=5, not ready), then B (ready); wb_pdest=5 in cycle t -> B issues first. A is issued at t+1 without the macro, and at t with IQ_WB_BYPASS_EN if issue_ready_i was held.
- Entry dispatched in the same cycle as wb of its src1 tag -> entry stored with src1_ready=1, issuable next cycle.
- Entries at indices 0,1,2, only index 1 ready, issue_ready_i=1 -> index 1 issues; old index 2 moves to index 1; cnt_q decreases by 1.
- flush_i with cnt_q=5 and 2 lanes dispatching -> issue_valid_o=0 that cycle; cnt_q=0 next cycle; no entry issues afterward.
